// File: rtl/pixel_stream_tx_if.sv
// rtl/pixel_stream_tx_if.sv - host write port, start/ready/done control and pixel stream bundle
interface pixel_stream_tx_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic [ADDR_WIDTH:0]   frame_len;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] pix_out;
  logic                  pix_valid;
  logic                  pix_last;
  logic                  pix_ready;
  logic [ADDR_WIDTH:0]   pix_count;

  // master: host plus pixel consumer; slave: the streamer itself
  modport master (
    output wr_en, wr_addr, wr_data, start, frame_len, pix_ready,
    input  ready, busy, done, pix_out, pix_valid, pix_last, pix_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, frame_len, pix_ready,
    output ready, busy, done, pix_out, pix_valid, pix_last, pix_count
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - frame buffer that streams its contents out at one pixel per cycle
module pixel_stream_tx #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int DEFAULT_LEN = 784
) (
  input  logic              clk,
  input  logic              rst,
  pixel_stream_tx_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         pix_count_q, pix_count_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] pix_out_q, pix_out_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  pix_last_q, pix_last_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         eff_len;
  logic                  handshake;

  // Writes are locked out while busy so the frame in flight cannot change.
  // rd_data_q only moves on rd_en, which is what keeps a stalled pixel's successor intact.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_comb begin
    eff_len = bus.frame_len;
    if (bus.frame_len == '0) begin
      eff_len = CW'(DEFAULT_LEN);
    end else if (bus.frame_len > CW'(DEPTH)) begin
      eff_len = CW'(DEPTH);
    end
  end

  assign handshake = pix_valid_q & bus.pix_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pix_count_d = pix_count_q;
    rd_ptr_d    = rd_ptr_q;
    pix_out_d   = pix_out_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d       = eff_len;
          pix_count_d = '0;
          rd_en       = 1'b1;
          rd_addr     = '0;
          rd_ptr_d    = ADDR_WIDTH'(1);
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: begin
        // Pixel 0 lands in the output register; pixel 1 is fetched behind it.
        pix_out_d   = rd_data_q;
        pix_valid_d = 1'b1;
        pix_last_d  = (len_q == CW'(1));
        rd_en       = 1'b1;
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        state_d     = S_STREAM;
      end

      S_STREAM: begin
        if (handshake) begin
          pix_count_d = pix_count_q + CW'(1);
          if (pix_last_q) begin
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            // Next presented index is pix_count_q + 1; it is last when that equals len - 1.
            pix_out_d  = rd_data_q;
            pix_last_d = (pix_count_q + CW'(2) == len_q);
            rd_en      = 1'b1;
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pix_count_q <= '0;
      rd_ptr_q    <= '0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pix_count_q <= pix_count_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pix_out   = pix_out_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_last  = pix_last_q;
  assign bus.pix_count = pix_count_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - scoreboard bench for pixel_stream_tx
module tb_pixel_stream_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_stream_tx_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();

  pixel_stream_tx #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (8),
    .DEFAULT_LEN(784)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         exp_len = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         first_cyc = -1;
  int         last_cyc = -1;
  logic [7:0] last_pix = 8'h00;
  int         rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[9:0];
    bus.wr_data = d[7:0];
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic push(input int d, input bit last);
    exp_t e;
    e.data = d[7:0];
    e.last = last;
    sbq.push_back(e);
  endtask

  task automatic push_small();
    for (int i = 0; i < 4; i++) push(8'h10 + i, i == 3);
  endtask

  task automatic begin_frame(input int flen, input int l, output int t);
    int n;
    n = 0;
    while (!bus.ready && n < 2000) begin
      step();
      n++;
    end
    chk("ready_before_start", bus.ready, 1);
    exp_len       = l;
    bus.frame_len = flen[10:0];
    bus.start     = 1'b1;
    t             = cyc;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  // Stream consumer backpressure pattern.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.pix_ready = ~bus.pix_ready;
      else bus.pix_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks holds and done.
  initial begin
    logic       prev_hold;
    logic       prev_valid;
    logic [7:0] prev_out;
    logic       prev_last;
    exp_t       e;
    prev_hold  = 1'b0;
    prev_valid = 1'b0;
    prev_out   = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", bus.pix_valid, 1);
          chk("hold_data", bus.pix_out, prev_out);
          chk("hold_last", bus.pix_last, prev_last);
        end
        if (bus.pix_valid && !prev_valid) first_cyc = cyc;
        if (bus.pix_valid && bus.pix_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pixel: got 0x%0h expected no pixel", bus.pix_out);
          end else begin
            e = sbq.pop_front();
            chk("pix_data", bus.pix_out, e.data);
            chk("pix_last", bus.pix_last, e.last);
          end
          if (bus.pix_last) begin
            last_cyc = cyc;
            last_pix = bus.pix_out;
          end
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_pix_count", bus.pix_count, exp_len);
          chk("done_sb_empty", sbq.size(), 0);
        end
        prev_hold  = bus.pix_valid && !bus.pix_ready;
        prev_valid = bus.pix_valid;
        prev_out   = bus.pix_out;
        prev_last  = bus.pix_last;
      end
    end
  end

  initial begin
    int t;
    int d0;
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_last", bus.pix_last, 0);
    chk("rst_out", bus.pix_out, 0);
    chk("rst_count", bus.pix_count, 0);
    step();
    rst = 1'b0;
    step();

    // Four-pixel frame, no backpressure, exact cycle timing.
    for (int i = 0; i < 4; i++) wr(i, 8'h10 + i);
    push_small();
    d0 = done_cnt;
    begin_frame(4, 4, t);
    wait_done(d0, 50);
    @(negedge clk);
    chk("t1_ready_after_done", bus.ready, 1);
    chk("t1_first_valid_cyc", first_cyc, t + 2);
    chk("t1_last_cyc", last_cyc, t + 5);
    chk("t1_done_cyc", done_cyc, t + 6);
    chk("t1_count", bus.pix_count, 4);
    chk("t1_pulses", done_cnt, d0 + 1);

    // Same frame under alternating backpressure.
    rdy_mode = 1;
    push_small();
    d0 = done_cnt;
    begin_frame(4, 4, t);
    wait_done(d0, 100);
    rdy_mode = 0;
    step();
    chk("t2_pulses", done_cnt, d0 + 1);
    chk("t2_count", bus.pix_count, 4);

    // start and a write while streaming are both ignored.
    push_small();
    d0 = done_cnt;
    begin_frame(4, 4, t);
    step();
    chk("t5_busy_mid", bus.busy, 1);
    bus.start     = 1'b1;
    bus.frame_len = 11'd4;
    wr(2, 8'hFF);
    bus.start     = 1'b0;
    wait_done(d0, 50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_idle_busy", bus.busy, 0);
      chk("t5_idle_valid", bus.pix_valid, 0);
    end
    chk("t5_pulses", done_cnt, d0 + 1);
    push_small();
    d0 = done_cnt;
    begin_frame(4, 4, t);
    wait_done(d0, 50);
    chk("t5_rerun_pulses", done_cnt, d0 + 1);

    // Reset while the third pixel is on the output.
    push(8'h10, 1'b0);
    push(8'h11, 1'b0);
    d0 = done_cnt;
    begin_frame(4, 4, t);
    step();
    step();
    step();
    chk("t6_third_pixel", bus.pix_out, 8'h12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", bus.pix_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_ready", bus.ready, 1);
    chk("t6_count", bus.pix_count, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_sb_empty", sbq.size(), 0);
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_done", done_cnt, d0);
    push_small();
    d0 = done_cnt;
    begin_frame(4, 4, t);
    wait_done(d0, 50);
    chk("t6_restart_pulses", done_cnt, d0 + 1);

    // Ramp buffer: default-length and clamped frames.
    for (int i = 0; i < 1024; i++) wr(i, i & 255);
    for (int i = 0; i < 784; i++) push(i & 255, i == 783);
    d0 = done_cnt;
    begin_frame(0, 784, t);
    wait_done(d0, 1000);
    step();
    chk("t3_count", bus.pix_count, 784);
    chk("t3_last_pix", last_pix, 8'h0F);
    chk("t3_last_cyc", last_cyc, t + 1 + 784);
    chk("t3_pulses", done_cnt, d0 + 1);

    for (int i = 0; i < 1024; i++) push(i & 255, i == 1023);
    d0 = done_cnt;
    begin_frame(2047, 1024, t);
    wait_done(d0, 1200);
    step();
    chk("t4_count", bus.pix_count, 1024);
    chk("t4_last_pix", last_pix, 8'hFF);
    chk("t4_last_cyc", last_cyc, t + 1 + 1024);
    chk("t4_pulses", done_cnt, d0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
